// File: rtl/sgd_v3.sv
// sgd_v3: streaming linear-regression trainer using stochastic gradient descent.
// It walks an external sample memory for E epochs of N samples. For each sample
// it forms y_hat = b + sum(w_i*x_i) in Q8.8, computes the error e, and then
// updates every weight and the bias by e*x_i / 2^lr.
module sgd_v3 #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  hold,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            feat,
  input  logic [7:0]            epoch,
  input  logic [ADDR_WIDTH-1:0] data_points,
  input  logic [3:0]            learn_rate,
  output logic [DATA_WIDTH-1:0] weights,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    MAC   = 3'd2,
    ERR   = 3'd3,
    UPD   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Field MAX_FEATURES of both the sample word and the weight word is special:
  // it holds the target y in a sample and the bias b in the weight word.
  localparam int BIAS = MAX_FEATURES;

  // Saturate a 32-bit signed intermediate to a Q8.8 value.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       sat16 = 16'sh7FFF;
    else if (v < -32'sd32768) sat16 = 16'sh8000;
    else                      sat16 = v[15:0];
  endfunction

  // Sign-extend a Q8.8 field to 32 bits.
  function automatic logic signed [31:0] sx(input logic [15:0] v);
    sx = {{16{v[15]}}, v};
  endfunction

  state_t state_q, state_d;

  // Configuration captured in IDLE. Inputs that change later have no effect.
  logic [3:0]            feat_q;
  logic [7:0]            epoch_q;
  logic [ADDR_WIDTH-1:0] npts_q;
  logic [3:0]            lr_q;

  // Walk counters: sample index, epoch, and feature index within MAC/UPD.
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [7:0]            ep_q;
  logic [3:0]            cnt_q;

  // Datapath registers.
  logic [DATA_WIDTH-1:0] data_q;
  logic signed [31:0]    acc_q;
  logic signed [15:0]    err_q;
  logic [LENGTH-1:0]     coef_q [0:MAX_FEATURES];

  // Shared datapath signals.
  logic [15:0]        x_cur;
  logic [15:0]        y_cur;
  logic [15:0]        mul_a;
  logic signed [31:0] prod;
  logic signed [31:0] prod_q8;
  logic signed [15:0] yhat;
  logic signed [15:0] err_d;
  logic signed [15:0] w_new;
  logic signed [15:0] b_new;
  logic               last_feat;
  logic               mac_last;
  logic               last_sample;
  logic               last_epoch;

  // Arithmetic. One multiplier is shared: MAC forms w_i*x_i and UPD forms e*x_i.
  always_comb begin
    x_cur       = data_q[cnt_q*LENGTH +: LENGTH];
    y_cur       = data_q[BIAS*LENGTH +: LENGTH];
    mul_a       = (state_q == MAC) ? coef_q[cnt_q] : err_q;
    prod        = sx(mul_a) * sx(x_cur);
    prod_q8     = prod >>> 8;
    yhat        = sat16(acc_q + sx(coef_q[BIAS]));
    err_d       = sat16(sx(yhat) - sx(y_cur));
    w_new       = sat16(sx(coef_q[cnt_q]) - (prod_q8 >>> lr_q));
    b_new       = sat16(sx(coef_q[BIAS]) - (sx(err_q) >>> lr_q));
    last_feat   = (cnt_q == feat_q);
    mac_last    = (cnt_q == feat_q - 4'd1);
    last_sample = (idx_q == npts_q - ADDR_WIDTH'(1));
    last_epoch  = (ep_q == epoch_q - 8'd1);
  end

  // State register. Reset wins over hold, and hold freezes the state.
  // NOTE: sequential state uses non-blocking (<=) so that every register
  // samples the pre-edge values, independent of the order of the blocks.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (!hold) begin
      unique case (state_q)
        IDLE:  state_d = (epoch == 8'd0 || data_points == '0) ? DONE : FETCH;
        FETCH: state_d = (feat_q == 4'd0) ? ERR : MAC;
        MAC:   if (mac_last) state_d = ERR;
        ERR:   state_d = UPD;
        UPD:   if (last_feat) state_d = (last_sample && last_epoch) ? DONE : FETCH;
        DONE:  state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and counters, advanced by the same state and hold as the FSM.
  // NOTE: the coefficient file is only 16 words and must read as zero right
  // after reset, so it is reset like ordinary flops instead of being left to
  // power-up contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      feat_q  <= '0;
      epoch_q <= '0;
      npts_q  <= '0;
      lr_q    <= '0;
      idx_q   <= '0;
      ep_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      acc_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i <= MAX_FEATURES; i++) coef_q[i] <= '0;
    end else if (!hold) begin
      unique case (state_q)
        IDLE: begin
          feat_q  <= feat;
          epoch_q <= epoch;
          npts_q  <= data_points;
          lr_q    <= learn_rate;
          idx_q   <= '0;
          ep_q    <= '0;
          cnt_q   <= '0;
          acc_q   <= '0;
          for (int i = 0; i <= MAX_FEATURES; i++) coef_q[i] <= '0;
        end
        FETCH: begin
          data_q <= data;
          acc_q  <= '0;
          cnt_q  <= '0;
        end
        MAC: begin
          acc_q <= acc_q + prod_q8;
          cnt_q <= mac_last ? 4'd0 : cnt_q + 4'd1;
        end
        ERR: begin
          err_q <= err_d;
          cnt_q <= '0;
        end
        UPD: begin
          if (!last_feat) begin
            coef_q[cnt_q] <= w_new;
            cnt_q         <= cnt_q + 4'd1;
          end else begin
            coef_q[BIAS] <= b_new;
            cnt_q        <= '0;
            if (!last_sample) begin
              idx_q <= idx_q + ADDR_WIDTH'(1);
            end else if (!last_epoch) begin
              ep_q  <= ep_q + 8'd1;
              idx_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: addr shows the sample index only while a sample is being worked on.
  always_comb begin
    addr = '0;
    if (state_q == FETCH || state_q == MAC || state_q == ERR || state_q == UPD)
      addr = idx_q;
    done = (state_q == DONE);
    for (int i = 0; i <= MAX_FEATURES; i++)
      weights[i*LENGTH +: LENGTH] = coef_q[i];
  end

endmodule

// File: tb/tb_sgd_v3.sv
// Testbench for sgd_v3: directed and randomized training runs. A
// floating-free integer model of the SGD rules gives the expected weights, and
// a progress counter gives the expected addr/done on every cycle.
module tb_sgd_v3;

  localparam int AW = 12;
  localparam int DW = 256;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          hold = 1'b0;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic [3:0]    feat = 4'd0;
  logic [7:0]    epoch = 8'd0;
  logic [AW-1:0] data_points = '0;
  logic [3:0]    learn_rate = 4'd0;
  logic [DW-1:0] weights;
  logic          done;

  logic [DW-1:0] mem [0:15];
  assign data = mem[addr[3:0]];

  int checks = 0;
  int errors = 0;

  sgd_v3 dut (
    .CLK(CLK), .RST(RST), .hold(hold), .data(data), .addr(addr),
    .feat(feat), .epoch(epoch), .data_points(data_points),
    .learn_rate(learn_rate), .weights(weights), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: plain integer SGD over the samples in mem.
  function automatic logic [DW-1:0] model_weights(input int f, input int n, input int e, input int lr);
    int w [16];
    int x [16];
    int y, acc, yhat, err, tmp;
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) w[i] = 0;
    for (int ep = 0; ep < e; ep++) begin
      for (int s = 0; s < n; s++) begin
        for (int i = 0; i < 16; i++) x[i] = int'($signed(mem[s][16*i +: 16]));
        y = x[15];
        acc = 0;
        for (int i = 0; i < f; i++) acc += (w[i] * x[i]) >>> 8;
        yhat = sat(acc + w[15]);
        err = sat(yhat - y);
        for (int i = 0; i < f; i++) w[i] = sat(w[i] - (((err * x[i]) >>> 8) >>> lr));
        w[15] = sat(w[15] - (err >>> lr));
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) begin
      tmp = w[i];
      r[16*i +: 16] = tmp[15:0];
    end
    return r;
  endfunction

  // One full run from reset: checks reset state, addr/done every cycle,
  // the edge at which done rises, and the final weights.
  task automatic run_case(input string name, input int f, input int n, input int e, input int lr,
                          input int hold_at, input int hold_len, input logic [DW-1:0] exp_w);
    int L, nominal, exp_edge, p, done_edge, exp_addr;
    logic h;
    L = 2 * f + 3;
    nominal = 1 + e * n * L;
    exp_edge = nominal + ((hold_len > 0 && hold_at <= nominal) ? hold_len : 0);
    feat = 4'(f); epoch = 8'(e); data_points = AW'(n); learn_rate = 4'(lr);
    hold = 1'b0; RST = 1'b1;
    @(posedge CLK); #1;
    check({name, " reset weights"}, weights, '0);
    check({name, " reset done"}, DW'(done), '0);
    check({name, " reset addr"}, DW'(addr), '0);
    RST = 1'b0;
    p = 0;
    done_edge = -1;
    for (int k = 1; k <= exp_edge + 4; k++) begin
      h = (k >= hold_at && k < hold_at + hold_len);
      hold = h;
      @(posedge CLK); #1;
      if (!h) p++;
      if (k == 1) begin
        feat = 4'($urandom); epoch = 8'($urandom);
        data_points = AW'($urandom); learn_rate = 4'($urandom);
      end
      if (done === 1'b1 && done_edge < 0) done_edge = k;
      exp_addr = (p == 0 || p >= nominal) ? 0 : ((p - 1) / L) % n;
      check($sformatf("%s addr k=%0d", name, k), DW'(addr), DW'(exp_addr));
      check($sformatf("%s done k=%0d", name, k), DW'(done), DW'(p >= nominal));
      if (k == exp_edge) check({name, " weights at done"}, weights, exp_w);
    end
    hold = 1'b0;
    check({name, " done edge"}, DW'(done_edge), DW'(exp_edge));
    check({name, " weights final"}, weights, exp_w);
  endtask

  initial begin
    logic [DW-1:0] exp;
    int f, n, e, lr, ha, hl;

    for (int s = 0; s < 16; s++) mem[s] = '0;

    // Single sample, single feature, lr 0 and 1.
    mem[0][15:0] = 16'h0100;
    mem[0][255:240] = 16'h0200;
    exp = '0; exp[15:0] = 16'h0200; exp[255:240] = 16'h0200;
    run_case("basic_lr0", 1, 1, 1, 0, 0, 0, exp);
    exp = '0; exp[15:0] = 16'h0100; exp[255:240] = 16'h0100;
    run_case("basic_lr1", 1, 1, 1, 1, 0, 0, exp);

    // Degenerate configurations finish right after IDLE.
    run_case("zero_epochs", 3, 2, 0, 0, 0, 0, '0);
    run_case("zero_points", 7, 0, 5, 0, 0, 0, '0);

    // Ten held cycles during MAC stretch the run but not the result.
    exp = '0; exp[15:0] = 16'h0200; exp[255:240] = 16'h0200;
    run_case("hold_mac", 1, 1, 1, 0, 3, 10, exp);

    // Saturating sample.
    mem[0] = '0;
    mem[0][15:0] = 16'h7FFF;
    mem[0][255:240] = 16'h8000;
    exp = '0; exp[15:0] = 16'h8000; exp[255:240] = 16'h8001;
    run_case("saturate", 1, 1, 1, 0, 0, 0, exp);

    // Abort mid-run (reset together with hold), then restart cleanly.
    feat = 4'd1; epoch = 8'd1; data_points = AW'(1); learn_rate = 4'd0;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("abort partial w0", DW'(weights[15:0]), DW'(16'h8000));
    check("abort partial done", DW'(done), '0);
    hold = 1'b1; RST = 1'b1;
    @(posedge CLK); #1;
    check("abort weights", weights, '0);
    check("abort done", DW'(done), '0);
    check("abort addr", DW'(addr), '0);
    hold = 1'b0; RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("restart done early", DW'(done), '0);
    @(posedge CLK); #1;
    check("restart done", DW'(done), DW'(1));
    check("restart weights", weights, exp);

    // Random samples: F=2, N=4, E=3.
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 16; i++) begin
        int v;
        v = int'($urandom_range(0, 1024)) - 512;
        mem[s][16*i +: 16] = v[15:0];
      end
    end
    run_case("f2_n4_e3", 2, 4, 3, 4, 0, 0, model_weights(2, 4, 3, 4));

    // Random configurations with random hold bursts.
    for (int t = 0; t < 5; t++) begin
      f  = int'($urandom_range(0, 15));
      n  = int'($urandom_range(1, 4));
      e  = int'($urandom_range(1, 3));
      lr = int'($urandom_range(0, 7));
      ha = int'($urandom_range(2, 30));
      hl = int'($urandom_range(0, 5));
      run_case($sformatf("rand%0d", t), f, n, e, lr, ha, hl, model_weights(f, n, e, lr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
